// File: rtl/matmul_uart_host_if.sv
// Host-side request/response bundle for matmul_uart_host.
// The master drives the request; the slave (the host block) drives the status and result.
interface matmul_uart_host_if;
  logic        start;
  logic [31:0] a_flat;
  logic [31:0] b_flat;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic        frame_err;
  logic [31:0] c_flat;

  modport master (
    output start, a_flat, b_flat,
    input  busy, done, timeout_err, frame_err, c_flat
  );

  modport slave (
    input  start, a_flat, b_flat,
    output busy, done, timeout_err, frame_err, c_flat
  );
endinterface

// File: rtl/matmul_uart_host.sv
// Host initiator for the 2x2 matrix-multiply UART protocol: sends A0..A3,B0..B3 as 8N1 frames,
// then collects the four result bytes C00,C01,C10,C11 with its own receive engine.
module matmul_uart_host #(
  parameter int unsigned CLKS_PER_BIT   = 10,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  matmul_uart_host_if.slave host,
  output logic              tx_serial,
  input  logic              rx_serial
);
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StTx, StRxWait, StDone} state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  state_e          state_q, state_d;
  logic [63:0]     shadow_q, shadow_d;
  logic            tx_q, tx_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [2:0]      tx_byte_q, tx_byte_d;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [2:0]      rx_idx_q, rx_idx_d;
  logic            armed_q, armed_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [31:0]     c_q, c_d;
  logic            timeout_err_q, timeout_err_d;
  logic            frame_err_q, frame_err_d;
  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  logic            rx_fall;
  logic            rx_all;

  assign rx_fall = rx_prev_q & ~rx_s2_q;
  assign rx_all  = (rx_idx_q == 3'd4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      shadow_q      <= '0;
      tx_q          <= 1'b1;
      tx_cnt_q      <= '0;
      tx_bit_q      <= '0;
      tx_byte_q     <= '0;
      rx_state_q    <= RxIdle;
      rx_cnt_q      <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_idx_q      <= '0;
      armed_q       <= 1'b0;
      tmo_q         <= '0;
      c_q           <= '0;
      timeout_err_q <= 1'b0;
      frame_err_q   <= 1'b0;
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_prev_q     <= 1'b1;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      tx_q          <= tx_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_bit_q      <= tx_bit_d;
      tx_byte_q     <= tx_byte_d;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rx_idx_q      <= rx_idx_d;
      armed_q       <= armed_d;
      tmo_q         <= tmo_d;
      c_q           <= c_d;
      timeout_err_q <= timeout_err_d;
      frame_err_q   <= frame_err_d;
      rx_s1_q       <= rx_serial;
      rx_s2_q       <= rx_s1_q;
      rx_prev_q     <= rx_s2_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    tx_d          = tx_q;
    tx_cnt_d      = tx_cnt_q;
    tx_bit_d      = tx_bit_q;
    tx_byte_d     = tx_byte_q;
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_idx_d      = rx_idx_q;
    armed_d       = armed_q;
    tmo_d         = tmo_q;
    c_d           = c_q;
    timeout_err_d = timeout_err_q;
    frame_err_d   = frame_err_q;

    // Saturating idle counter; cleared below on arming and on every start-bit detection.
    if (armed_q && (tmo_q != TmoLast)) begin
      tmo_d = tmo_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (host.start) begin
          state_d       = StTx;
          shadow_d      = {host.b_flat, host.a_flat};
          tx_d          = 1'b0;
          tx_cnt_d      = '0;
          tx_bit_d      = '0;
          tx_byte_d     = '0;
          rx_idx_d      = '0;
          timeout_err_d = 1'b0;
          frame_err_d   = 1'b0;
        end
      end
      StTx: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_bit_d = '0;
            if (tx_byte_q == 3'd7) begin
              state_d = StRxWait;
              tx_d    = 1'b1;
            end else begin
              tx_byte_d = tx_byte_q + 3'd1;
              tx_d      = 1'b0;
              // The responder may answer before our last stop bit, so listen from byte 8 on.
              if (tx_byte_q == 3'd6) begin
                armed_d = 1'b1;
                tmo_d   = '0;
              end
            end
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            if (tx_bit_q == 4'd8) begin
              tx_d = 1'b1;
            end else begin
              // Shadow doubles as the shift register: the next byte lands in [7:0] on its own.
              tx_d     = shadow_q[0];
              shadow_d = shadow_q >> 1;
            end
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      StRxWait: begin
        if (rx_all) begin
          state_d = StDone;
          armed_d = 1'b0;
        end else if (tmo_q == TmoLast) begin
          state_d       = StDone;
          armed_d       = 1'b0;
          timeout_err_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    unique case (rx_state_q)
      RxIdle: begin
        if (armed_q && rx_fall) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
          tmo_d      = '0;
        end
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RxStop;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_state_d = RxIdle;
          if (!rx_s2_q) begin
            frame_err_d = 1'b1;
          end else if (!rx_all) begin
            c_d[{rx_idx_q[1:0], 3'b000} +: 8] = rx_shift_q;
            rx_idx_d                          = rx_idx_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: begin
        rx_state_d = RxIdle;
      end
    endcase

    // A disarmed engine drops any partial frame, so late bytes never reach c_flat.
    if (!armed_q) begin
      rx_state_d = RxIdle;
    end
  end

  assign tx_serial        = tx_q;
  assign host.busy        = (state_q != StIdle);
  assign host.done        = (state_q == StDone);
  assign host.timeout_err = timeout_err_q;
  assign host.frame_err   = frame_err_q;
  assign host.c_flat      = c_q;
endmodule

// File: tb/tb_matmul_uart_host.sv
// Bench for matmul_uart_host: a UART responder model answers the host, a TX monitor checks the
// outgoing byte stream, and a result monitor compares every done pulse against a scoreboard.
module tb_matmul_uart_host;
  localparam int unsigned CPB = 10;
  localparam int unsigned TMO = 300;

  typedef struct packed {
    logic [31:0] c;
    logic        tmo;
    logic        ferr;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_line = 1'b1;
  logic tx_serial;

  matmul_uart_host_if hif ();

  matmul_uart_host #(
    .CLKS_PER_BIT  (CPB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .host     (hif),
    .tx_serial(tx_serial),
    .rx_serial(rx_line)
  );

  always #5 clk = ~clk;

  res_t       sb_q[$];
  logic [7:0] exp_tx_q[$];
  logic [7:0] resp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int arm_cyc = 0;
  int done_cyc = 0;
  int tm_nbyte = 0;
  int resp_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // TX monitor: decodes 8N1 frames on tx_serial, compares against expected bytes, feeds responder.
  initial begin : tx_mon
    int unsigned cnt;
    int unsigned k;
    logic [7:0]  sh;
    logic        act;
    logic        prev;
    cnt = 0; k = 0; sh = '0; act = 1'b0; prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        act  = 1'b0;
        prev = 1'b1;
      end else if (!act) begin
        if (prev && !tx_serial) begin
          act = 1'b1;
          cnt = 0;
          if (tm_nbyte == 7) arm_cyc = cyc;
          tm_nbyte++;
        end
        prev = tx_serial;
      end else begin
        cnt++;
        if (cnt >= CPB / 2 && (cnt - CPB / 2) % CPB == 0) begin
          k = (cnt - CPB / 2) / CPB;
          if (k >= 1 && k <= 8) begin
            sh = {tx_serial, sh[7:1]};
          end else if (k == 9) begin
            act  = 1'b0;
            prev = tx_serial;
            check("tx_stop_bit", 32'(tx_serial), 32'd1);
            if (exp_tx_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL tx_unexpected_byte: got %h required no byte", sh);
            end else begin
              check("tx_byte", 32'(sh), 32'(exp_tx_q.pop_front()));
            end
            resp_q.push_back(sh);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx_line = stop;
    repeat (CPB) @(negedge clk);
    rx_line = 1'b1;
    if (!stop) repeat (CPB) @(negedge clk);
  endtask

  // Responder model: mode 0 normal, 1 silent, 2 second result byte framed with stop=0.
  initial begin : responder
    logic [7:0] m[8];
    logic [7:0] c[4];
    int         v;
    forever begin
      @(negedge clk);
      if (resp_q.size() >= 8) begin
        for (int i = 0; i < 8; i++) m[i] = resp_q.pop_front();
        v = int'(m[0]) * int'(m[4]) + int'(m[1]) * int'(m[6]); c[0] = 8'(v);
        v = int'(m[0]) * int'(m[5]) + int'(m[1]) * int'(m[7]); c[1] = 8'(v);
        v = int'(m[2]) * int'(m[4]) + int'(m[3]) * int'(m[6]); c[2] = 8'(v);
        v = int'(m[2]) * int'(m[5]) + int'(m[3]) * int'(m[7]); c[3] = 8'(v);
        repeat (2) @(negedge clk);
        if (resp_mode == 0) begin
          for (int i = 0; i < 4; i++) send_byte(c[i], 1'b1);
        end else if (resp_mode == 2) begin
          send_byte(c[0], 1'b1);
          send_byte(c[1], 1'b0);
          send_byte(c[2], 1'b1);
          send_byte(c[3], 1'b1);
        end
      end
    end
  end

  // Result monitor: every done pulse pops one expectation.
  initial begin : res_mon
    res_t e;
    logic chk_busy;
    chk_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_busy) begin
        check("busy_after_done", 32'(hif.busy), 32'd0);
        chk_busy = 1'b0;
      end
      if (hif.done === 1'b1) begin
        done_cyc = cyc;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 required done=0");
        end else begin
          e = sb_q.pop_front();
          check("c_flat", hif.c_flat, e.c);
          check("timeout_err", 32'(hif.timeout_err), 32'(e.tmo));
          check("frame_err", 32'(hif.frame_err), 32'(e.ferr));
          check("busy_with_done", 32'(hif.busy), 32'd1);
          chk_busy = 1'b1;
        end
      end
    end
  end

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input int mode,
                        input logic [31:0] c, input logic tmo, input logic ferr);
    res_t e;
    resp_mode = mode;
    tm_nbyte  = 0;
    for (int i = 0; i < 4; i++) exp_tx_q.push_back(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) exp_tx_q.push_back(b[8*i +: 8]);
    e.c = c; e.tmo = tmo; e.ferr = ferr;
    sb_q.push_back(e);
    hif.a_flat = a;
    hif.b_flat = b;
    hif.start  = 1'b1;
    @(negedge clk);
    hif.start  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_no_done: got no done in %0d cycles required done", name, n);
      sb_q.delete();
    end
    repeat (5) @(negedge clk);
    check({name, "_tx_idle"}, 32'(tx_serial), 32'd1);
    check({name, "_busy_idle"}, 32'(hif.busy), 32'd0);
  endtask

  task automatic wait_tx_bytes(input int nb);
    int n;
    n = 0;
    while (tm_nbyte < nb && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (tm_nbyte < nb) begin
      checks++;
      failures++;
      $display("FAIL tx_progress: got %0d bytes required %0d", tm_nbyte, nb);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hif.start  = 1'b0;
    hif.a_flat = '0;
    hif.b_flat = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_serial), 32'd1);
    check("rst_busy", 32'(hif.busy), 32'd0);
    check("rst_done", 32'(hif.done), 32'd0);
    check("rst_timeout_err", 32'(hif.timeout_err), 32'd0);
    check("rst_frame_err", 32'(hif.frame_err), 32'd0);
    check("rst_c_flat", hif.c_flat, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: basic multiply.
    launch(32'h04030201, 32'h08070605, 0, 32'h322B1613, 1'b0, 1'b0);
    wait_done("case1");

    // 2: all 255, results wrap to 0x02.
    launch(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h02020202, 1'b0, 1'b0);
    wait_done("case2");

    // 3: silent responder, timeout measured from arming.
    launch(32'h04030201, 32'h08070605, 1, 32'h02020202, 1'b1, 1'b0);
    wait_done("case3");
    check("case3_timeout_latency", 32'(done_cyc - arm_cyc), 32'(TMO));

    // 4: second reply byte has a bad stop bit; three stored, slot 3 keeps 0x02.
    launch(32'h04030201, 32'h08070605, 2, 32'h02322B13, 1'b1, 1'b1);
    wait_done("case4");

    // 5: reset in the middle of the 4th TX byte (during D0, which is 0).
    launch(32'h04030201, 32'h08070605, 0, 32'h322B1613, 1'b0, 1'b0);
    wait_tx_bytes(4);
    repeat (15) @(negedge clk);
    check("case5_tx_low_before_rst", 32'(tx_serial), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("case5_rst_tx", 32'(tx_serial), 32'd1);
    check("case5_rst_busy", 32'(hif.busy), 32'd0);
    check("case5_rst_c_flat", hif.c_flat, 32'd0);
    exp_tx_q.delete();
    resp_q.delete();
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    launch(32'h04030201, 32'h08070605, 0, 32'h322B1613, 1'b0, 1'b0);
    wait_done("case5_rerun");

    // 6: start while busy and an rx glitch before arming are both ignored.
    launch(32'h04030201, 32'h08070605, 0, 32'h322B1613, 1'b0, 1'b0);
    wait_tx_bytes(2);
    repeat (5) @(negedge clk);
    hif.start = 1'b1;
    @(negedge clk);
    hif.start = 1'b0;
    rx_line = 1'b0;
    @(negedge clk);
    rx_line = 1'b1;
    wait_done("case6");
    repeat (200) @(negedge clk);
    check("case6_still_idle", 32'(hif.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
